// File: rtl/exception_ctrl.sv
// Exception/return sequencer: arbitrates exception sources, captures EPC/cause,
// and emits registered exception/rfe pulses, fetch redirect and pipeline flush.
module exception_ctrl #(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0080,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq,
    input  logic        sys_call,
    input  logic        illegal_op,
    input  logic        ovf,
    input  logic        rfe_op,
    input  logic [31:0] pc_in,
    input  logic        IE_c,
    input  logic        s_u_c,
    output logic        exception,
    output logic        rfe,
    output logic        redirect,
    output logic [31:0] next_pc,
    output logic        flush,
    output logic [31:0] epc,
    output logic [31:0] cause
);

    typedef enum logic [1:0] {IDLE, TAKE, RETURN, FLUSH} state_t;

    localparam logic [3:0] CNT_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  cause_q, cause_d;
    logic        exc_q, exc_d;
    logic        rfe_q, rfe_d;
    logic        red_q, red_d;
    logic        flush_q, flush_d;
    logic [31:0] npc_q, npc_d;

    logic        take;
    logic [4:0]  code;

    // Fixed-priority source arbitration; a user-mode rfe is a privilege violation.
    always_comb begin
        take = 1'b1;
        code = 5'd0;
        if (illegal_op)                code = 5'd10;
        else if (rfe_op && !s_u_c)     code = 5'd11;
        else if (sys_call)             code = 5'd8;
        else if (ovf)                  code = 5'd12;
        else if (irq && IE_c)          code = 5'd0;
        else                           take = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    epc_d   = pc_in;
                    cause_d = code;
                    state_d = TAKE;
                end else if (rfe_op && s_u_c) begin
                    state_d = RETURN;
                end
            end
            TAKE, RETURN: begin
                if (FLUSH_CYCLES == 1) begin
                    state_d = IDLE;
                end else begin
                    state_d = FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave flops aligned with it.
        exc_d   = (state_d == TAKE);
        rfe_d   = (state_d == RETURN);
        red_d   = (state_d == TAKE) || (state_d == RETURN);
        flush_d = (state_d != IDLE);
        if (state_d == TAKE)        npc_d = VECTOR_ADDR;
        else if (state_d == RETURN) npc_d = epc_q;
        else                        npc_d = npc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            epc_q   <= 32'd0;
            cause_q <= 5'd0;
            exc_q   <= 1'b0;
            rfe_q   <= 1'b0;
            red_q   <= 1'b0;
            flush_q <= 1'b0;
            npc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            exc_q   <= exc_d;
            rfe_q   <= rfe_d;
            red_q   <= red_d;
            flush_q <= flush_d;
            npc_q   <= npc_d;
        end
    end

    assign exception = exc_q;
    assign rfe       = rfe_q;
    assign redirect  = red_q;
    assign flush     = flush_q;
    assign next_pc   = npc_q;
    assign epc       = epc_q;
    assign cause     = {27'd0, cause_q};

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Exception/return sequencer that generates the `exception` and `rfe` pulses consumed by the status register.
- Arbitrates synchronous exception sources and the external interrupt, and captures EPC and cause.
- Redirects the fetch PC to the vector or back to EPC, and flushes the pipeline.
- Sits between instruction decode/execute and the status register; reads back `IE_c` and `s_u_c`.

Parameters:
- VECTOR_ADDR, 32'h0000_0080, fetch target on any exception.
- FLUSH_CYCLES, 2, total cycles `flush` is held high per event, counted from the TAKE/RETURN cycle; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- irq  input  1  external interrupt request, level.
- sys_call  input  1  syscall decoded in the current instruction.
- illegal_op  input  1  undefined opcode in the current instruction.
- ovf  input  1  arithmetic overflow from the current instruction.
- rfe_op  input  1  rfe instruction decoded.
- pc_in  input  32  PC of the current instruction.
- IE_c  input  1  interrupt enable, from the status register.
- s_u_c  input  1  1 = supervisor, 0 = user, from the status register.
- exception  output  1  one-cycle registered pulse; status register pushes mode.
- rfe  output  1  one-cycle registered pulse; status register pops mode.
- redirect  output  1  fetch must load `next_pc` this cycle.
- next_pc  output  32  redirect target.
- flush  output  1  squash instructions in flight.
- epc  output  32  saved exception PC.
- cause  output  32  bits [4:0] hold the cause code; bits [31:5] are 0.

Behaviour:
- States: IDLE, TAKE, RETURN, FLUSH. A 4-bit flush counter supports FLUSH.
- Reset (async, any state):
  - state = IDLE.
  - exception, rfe, redirect, flush = 0.
  - next_pc, epc, cause = 0.
  - Flush counter = 0.
  - An event in progress is abandoned; no partial pulse may remain.
- Source sampling happens in IDLE only. Priority, highest first:
  - illegal_op: code 10.
  - rfe_op with s_u_c = 0 (privilege violation): code 11.
  - sys_call: code 8.
  - ovf: code 12.
  - irq with IE_c = 1: code 0.
  - irq with IE_c = 0 is ignored.
- Exception capture: on the IDLE edge where any enabled source is present:
  - epc <= pc_in; cause[4:0] <= winning code.
  - state -> TAKE.
- Return capture: if no exception source and rfe_op = 1 with s_u_c = 1, state -> RETURN. epc and cause are unchanged.
- TAKE (exactly 1 cycle):
  - exception = 1, redirect = 1, next_pc = VECTOR_ADDR, flush = 1.
- RETURN (exactly 1 cycle):
  - rfe = 1, redirect = 1, next_pc = epc, flush = 1.
- Exit from TAKE/RETURN:
  - FLUSH_CYCLES = 1: go to IDLE.
  - Otherwise: go to FLUSH with the counter loaded to FLUSH_CYCLES-2.
- FLUSH:
  - flush = 1; redirect, exception, rfe = 0.
  - Counter decrements each cycle; at 0, go to IDLE.
- Source masking: all sources are ignored in TAKE, RETURN and FLUSH; flushed instructions never raise exceptions.
  - A held irq is re-evaluated in IDLE against the current IE_c. IE_c is 0 after an exception, so irq is not re-taken until software re-enables it.
- Latency: source asserted in IDLE -> exception/redirect high on the next cycle (1-cycle latency). The same holds for rfe.
- Pulse rules (the status register is edge-triggered):
  - exception and rfe come directly from flops, are glitch-free, and are high for exactly one clk cycle.
  - They are never high together.
  - Minimum spacing between two pulses is FLUSH_CYCLES+1 cycles.
- Simultaneous events:
  - An exception source beats rfe_op. epc = pc_in of the rfe instruction; no rfe pulse.
  - irq together with a synchronous source: the synchronous source wins; irq is retried later.
- Outputs: all outputs are registered; no combinational path from inputs to outputs.
- epc/cause hold their value until the next exception capture.

Test Plan:
- Reset: rst = 1 mid-FLUSH -> all outputs 0 asynchronously; after release, state IDLE and epc = 0.
- Syscall: sys_call = 1, pc_in = 32'h0000_1004 -> next cycle: exception = 1 for one cycle, redirect = 1, next_pc = 32'h0000_0080, epc = 32'h0000_1004, cause = 8. flush is high for 2 cycles; sources are ignored during them.
- Priority: illegal_op = ovf = irq = 1, IE_c = 1 -> cause = 10, a single exception pulse.
- Masked interrupt: irq = 1, IE_c = 0 for 20 cycles -> no exception. Then IE_c = 1 -> exception with cause = 0.
- rfe in supervisor: epc = 32'h0000_2000, rfe_op = 1, s_u_c = 1 -> rfe pulse of one cycle, next_pc = 32'h0000_2000, exception stays 0.
- rfe in user mode: rfe_op = 1, s_u_c = 0, pc_in = 32'h0000_3008 -> exception with cause = 11, epc = 32'h0000_3008, rfe stays 0.
- FLUSH_CYCLES = 1 build: flush is high exactly in the TAKE cycle, and a new exception can be taken 2 cycles after the previous one.
